// File: rtl/hazard_ctrl_if.sv
// D-stage hazard bundle: classifier tuple in, stall and forwarding selects out.
// master = pipeline/classifier side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [1:0]  Tuse_rs;
  logic [1:0]  Tuse_rt;
  logic [1:0]  TnewD;
  logic [4:0]  A_rsD;
  logic [4:0]  A_rtD;
  logic [4:0]  AwriteD;
  logic        stall;
  logic [1:0]  FwdRsD;
  logic [1:0]  FwdRtD;
  logic [1:0]  FwdRsE;
  logic [1:0]  FwdRtE;
  logic [1:0]  FwdRtM;
  logic [31:0] stall_cnt;

  modport master (
    output Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
    input  stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, stall_cnt
  );

  modport slave (
    input  Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
    output stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: tracks Tnew/address shadows for E/M/W and
// drives the D stall plus forwarding selects. Optional macro HAZARD_STAT_EN adds a stall counter.
module hazard_ctrl (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hif
);

  // Only the fields a consumer actually reads are kept: rs/rt in E, rt in M,
  // and the destination in W (whose Tnew is always 0).
  logic [4:0] r_a_rs_e;
  logic [4:0] r_a_rt_e;
  logic [4:0] r_awrite_e;
  logic [1:0] r_tnew_e;
  logic [4:0] r_a_rt_m;
  logic [4:0] r_awrite_m;
  logic [1:0] r_tnew_m;
  logic [4:0] r_awrite_w;

  logic       w_stall_rs;
  logic       w_stall_rt;
  logic       w_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic src_stall(
    input logic [4:0] a,
    input logic [1:0] tuse,
    input logic [4:0] aw_e,
    input logic [1:0] tn_e,
    input logic [4:0] aw_m,
    input logic [1:0] tn_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (a == aw_e) && (tuse < tn_e);
    hit_m = (a == aw_m) && (tuse < tn_m);
    return (a != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  function automatic logic [1:0] fwd_d(
    input logic [4:0] a,
    input logic [4:0] aw_e,
    input logic [1:0] tn_e,
    input logic [4:0] aw_m,
    input logic [1:0] tn_m,
    input logic [4:0] aw_w
  );
    if (a == 5'd0)                                    return 2'd0;
    else if (aw_e != 5'd0 && aw_e == a && tn_e == 2'd0) return 2'd1;
    else if (aw_m != 5'd0 && aw_m == a && tn_m == 2'd0) return 2'd2;
    else if (aw_w != 5'd0 && aw_w == a)                 return 2'd3;
    else                                              return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] a,
    input logic [4:0] aw_m,
    input logic [1:0] tn_m,
    input logic [4:0] aw_w
  );
    if (a == 5'd0)                                    return 2'd0;
    else if (aw_m != 5'd0 && aw_m == a && tn_m == 2'd0) return 2'd2;
    else if (aw_w != 5'd0 && aw_w == a)                 return 2'd3;
    else                                              return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_m(
    input logic [4:0] a,
    input logic [4:0] aw_w
  );
    return (a != 5'd0 && aw_w != 5'd0 && aw_w == a) ? 2'd3 : 2'd0;
  endfunction

  assign w_stall_rs = src_stall(hif.A_rsD, hif.Tuse_rs, r_awrite_e, r_tnew_e,
                                r_awrite_m, r_tnew_m);
  assign w_stall_rt = src_stall(hif.A_rtD, hif.Tuse_rt, r_awrite_e, r_tnew_e,
                                r_awrite_m, r_tnew_m);
  assign w_stall    = w_stall_rs | w_stall_rt;

  assign hif.stall  = w_stall;
  assign hif.FwdRsD = fwd_d(hif.A_rsD, r_awrite_e, r_tnew_e, r_awrite_m, r_tnew_m, r_awrite_w);
  assign hif.FwdRtD = fwd_d(hif.A_rtD, r_awrite_e, r_tnew_e, r_awrite_m, r_tnew_m, r_awrite_w);
  assign hif.FwdRsE = fwd_e(r_a_rs_e, r_awrite_m, r_tnew_m, r_awrite_w);
  assign hif.FwdRtE = fwd_e(r_a_rt_e, r_awrite_m, r_tnew_m, r_awrite_w);
  assign hif.FwdRtM = fwd_m(r_a_rt_m, r_awrite_w);

  // D -> E: a stall turns E into a bubble while M and W keep draining.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_rs_e   <= 5'd0;
      r_a_rt_e   <= 5'd0;
      r_awrite_e <= 5'd0;
      r_tnew_e   <= 2'd0;
      r_a_rt_m   <= 5'd0;
      r_awrite_m <= 5'd0;
      r_tnew_m   <= 2'd0;
      r_awrite_w <= 5'd0;
    end else begin
      if (w_stall) begin
        r_a_rs_e   <= 5'd0;
        r_a_rt_e   <= 5'd0;
        r_awrite_e <= 5'd0;
        r_tnew_e   <= 2'd0;
      end else begin
        r_a_rs_e   <= hif.A_rsD;
        r_a_rt_e   <= hif.A_rtD;
        r_awrite_e <= hif.AwriteD;
        r_tnew_e   <= sat_dec(hif.TnewD);
      end
      // E -> M -> W
      r_a_rt_m   <= r_a_rt_e;
      r_awrite_m <= r_awrite_e;
      r_tnew_m   <= sat_dec(r_tnew_e);
      r_awrite_w <= r_awrite_m;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)     r_stall_cnt <= 32'h0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'h1;
  end

  assign hif.stall_cnt = r_stall_cnt;
`else
  assign hif.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, ALU/load/branch hazards, $0, priority.
module tb_hazard_ctrl;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic [1:0] trs, input logic [1:0] trt, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] aw);
    hif.Tuse_rs = trs;
    hif.Tuse_rt = trt;
    hif.TnewD   = tn;
    hif.A_rsD   = rs;
    hif.A_rtD   = rt;
    hif.AwriteD = aw;
  endtask

  task automatic nop();
    set_d(2'd3, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    nop();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_d(2'd0, 2'd1, 2'd3, 5'd5, 5'd7, 5'd5);
    tick();
    set_d(2'd1, 2'd0, 2'd2, 5'd7, 5'd5, 5'd7);
    tick();
    reset_n = 1'b1;
    nop();
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRsD !== 2'd0) begin n_fail++; $display("FAIL reset_FwdRsD: got %0d want 0", hif.FwdRsD); end
    n_checks++; if (hif.FwdRtD !== 2'd0) begin n_fail++; $display("FAIL reset_FwdRtD: got %0d want 0", hif.FwdRtD); end
    n_checks++; if (hif.FwdRsE !== 2'd0) begin n_fail++; $display("FAIL reset_FwdRsE: got %0d want 0", hif.FwdRsE); end
    n_checks++; if (hif.FwdRtE !== 2'd0) begin n_fail++; $display("FAIL reset_FwdRtE: got %0d want 0", hif.FwdRtE); end
    n_checks++; if (hif.FwdRtM !== 2'd0) begin n_fail++; $display("FAIL reset_FwdRtM: got %0d want 0", hif.FwdRtM); end
    n_checks++; if (hif.stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hif.stall_cnt); end
  endtask

  task automatic test_alu_chain();
    pulse_reset();
    set_d(2'd1, 2'd1, 2'd2, 5'd1, 5'd2, 5'd3);   // addu $3,$1,$2
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL alu_prod_stall: got %b want 0", hif.stall); end
    tick();
    set_d(2'd1, 2'd3, 2'd2, 5'd3, 5'd0, 5'd6);   // addu $6,$3,$0
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL alu_cons_stall: got %b want 0", hif.stall); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.FwdRsE !== 2'd2) begin n_fail++; $display("FAIL alu_FwdRsE: got %0d want 2", hif.FwdRsE); end
    n_checks++; if (hif.FwdRtE !== 2'd0) begin n_fail++; $display("FAIL alu_FwdRtE: got %0d want 0", hif.FwdRtE); end
  endtask

  task automatic test_load_use();
    logic [31:0] exp_cnt;
`ifdef HAZARD_STAT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    pulse_reset();
    set_d(2'd1, 2'd3, 2'd3, 5'd1, 5'd0, 5'd5);   // lw $5,0($1)
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %b want 0", hif.stall); end
    tick();
    set_d(2'd1, 2'd3, 2'd2, 5'd5, 5'd0, 5'd8);   // addu $8,$5,$0
    #1;
    n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %b want 1", hif.stall); end
    tick();
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRsD !== 2'd0) begin n_fail++; $display("FAIL lu_FwdRsD: got %0d want 0", hif.FwdRsD); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.FwdRsE !== 2'd3) begin n_fail++; $display("FAIL lu_FwdRsE: got %0d want 3", hif.FwdRsE); end
    n_checks++; if (hif.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt: got %0d want %0d", hif.stall_cnt, exp_cnt); end
  endtask

  task automatic test_load_branch();
    logic [31:0] exp_cnt;
`ifdef HAZARD_STAT_EN
    exp_cnt = 32'd2;
`else
    exp_cnt = 32'd0;
`endif
    pulse_reset();
    set_d(2'd1, 2'd3, 2'd3, 5'd1, 5'd0, 5'd7);   // lw $7
    tick();
    set_d(2'd0, 2'd0, 2'd0, 5'd7, 5'd7, 5'd0);   // beq $7,$7
    #1;
    n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall1: got %b want 1", hif.stall); end
    tick();
    #1;
    n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall2: got %b want 1", hif.stall); end
    tick();
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL lb_stall3: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRsD !== 2'd3) begin n_fail++; $display("FAIL lb_FwdRsD: got %0d want 3", hif.FwdRsD); end
    n_checks++; if (hif.FwdRtD !== 2'd3) begin n_fail++; $display("FAIL lb_FwdRtD: got %0d want 3", hif.FwdRtD); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lb_cnt: got %0d want %0d", hif.stall_cnt, exp_cnt); end
  endtask

  task automatic test_d_forward();
    pulse_reset();
    set_d(2'd3, 2'd3, 2'd1, 5'd0, 5'd0, 5'd9);   // lui $9 (Tnew=1)
    tick();
    set_d(2'd0, 2'd3, 2'd0, 5'd9, 5'd0, 5'd0);   // beq $9
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL dfE_stall: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRsD !== 2'd1) begin n_fail++; $display("FAIL dfE_FwdRsD: got %0d want 1", hif.FwdRsD); end
    pulse_reset();
    set_d(2'd1, 2'd1, 2'd2, 5'd1, 5'd2, 5'd10);  // addu $10
    tick();
    set_d(2'd3, 2'd0, 2'd0, 5'd0, 5'd10, 5'd0);  // beq $0,$10
    #1;
    n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL dfM_stall1: got %b want 1", hif.stall); end
    tick();
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL dfM_stall2: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRtD !== 2'd2) begin n_fail++; $display("FAIL dfM_FwdRtD: got %0d want 2", hif.FwdRtD); end
  endtask

  task automatic test_zero_writer();
    pulse_reset();
    set_d(2'd1, 2'd3, 2'd2, 5'd1, 5'd0, 5'd0);   // ori $0,$1,imm
    tick();
    set_d(2'd1, 2'd3, 2'd2, 5'd0, 5'd0, 5'd4);   // addu $4,$0,...
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL z_stall: got %b want 0", hif.stall); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.FwdRsE !== 2'd0) begin n_fail++; $display("FAIL z_FwdRsE: got %0d want 0", hif.FwdRsE); end
    pulse_reset();
    set_d(2'd1, 2'd3, 2'd3, 5'd1, 5'd0, 5'd0);   // lw $0
    tick();
    set_d(2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);   // beq $0,$0
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL z_lw_stall: got %b want 0", hif.stall); end
    n_checks++; if (hif.FwdRsD !== 2'd0) begin n_fail++; $display("FAIL z_lw_FwdRsD: got %0d want 0", hif.FwdRsD); end
  endtask

  task automatic test_priority();
    pulse_reset();
    set_d(2'd3, 2'd3, 2'd1, 5'd0, 5'd0, 5'd4);   // lui $4
    tick();
    set_d(2'd1, 2'd1, 2'd2, 5'd1, 5'd2, 5'd4);   // addu $4
    tick();
    set_d(2'd1, 2'd2, 2'd0, 5'd0, 5'd4, 5'd0);   // sw $4,0($0)
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL pr_stall: got %b want 0", hif.stall); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.FwdRtE !== 2'd2) begin n_fail++; $display("FAIL pr_FwdRtE: got %0d want 2", hif.FwdRtE); end
    n_checks++; if (hif.FwdRsE !== 2'd0) begin n_fail++; $display("FAIL pr_FwdRsE: got %0d want 0", hif.FwdRsE); end
    tick();
    #1;
    n_checks++; if (hif.FwdRtM !== 2'd3) begin n_fail++; $display("FAIL pr_FwdRtM: got %0d want 3", hif.FwdRtM); end
  endtask

  task automatic test_reset_in_stall();
    pulse_reset();
    set_d(2'd1, 2'd3, 2'd3, 5'd1, 5'd0, 5'd5);   // lw $5
    tick();
    set_d(2'd1, 2'd3, 2'd2, 5'd5, 5'd0, 5'd8);   // addu $8,$5
    #1;
    n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL rs_stall_pre: got %b want 1", hif.stall); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL rs_stall_post: got %b want 0", hif.stall); end
    n_checks++; if (hif.stall_cnt !== 32'h0) begin n_fail++; $display("FAIL rs_cnt: got %0d want 0", hif.stall_cnt); end
    tick();
    nop();
    #1;
    n_checks++; if (hif.FwdRsE !== 2'd0) begin n_fail++; $display("FAIL rs_FwdRsE: got %0d want 0", hif.FwdRsE); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    nop();
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_load_branch();
    test_d_forward();
    test_zero_writer();
    test_priority();
    test_reset_in_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Consumes the per-instruction Tuse/Tnew/register-address tuple produced by the D-stage instruction classifier. It tracks that tuple through private E/M/W shadow registers and produces the D-stage stall plus all forwarding-mux selects. It is the only consumer of the classifier's outputs and sits beside the pipeline registers, clocked in lockstep with them.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- Tuse_rs  in  2  cycles until D-stage instr needs rs; 3 = rs unused
- Tuse_rt  in  2  same for rt
- TnewD  in  2  cycles (counted from D) until result is forwardable; 0 = no result
- A_rsD  in  5  rs address of D instr (0 if unused)
- A_rtD  in  5  rt address of D instr (0 if unused)
- AwriteD  in  5  destination of D instr (0 = none)
- stall  out  1  freeze PC and F/D; insert bubble into E
- FwdRsD  out  2  D-stage rs mux: 0 RF, 1 E, 2 M, 3 W
- FwdRtD  out  2  D-stage rt mux, same encoding
- FwdRsE  out  2  E-stage rs mux: 0 pipe reg, 2 M, 3 W
- FwdRtE  out  2  E-stage rt mux, same
- FwdRtM  out  2  M-stage rt (store data): 0 pipe reg, 3 W
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Shadow state per stage X∈{E,M,W}: A_rsX, A_rtX, AwriteX (5b), TnewX (2b).
- Advance each edge: E ← D tuple with TnewE = sat(TnewD−1); M ← E with TnewM = sat(TnewE−1); W ← M with TnewW = 0. sat() floors at 0.
- While stall=1: E loads bubble (all fields 0); M and W advance normally.
- stall_rs = (A_rsD≠0) ∧ (Tuse_rs≠3) ∧ [(A_rsD=AwriteE ∧ Tuse_rs<TnewE) ∨ (A_rsD=AwriteM ∧ Tuse_rs<TnewM)]. stall_rt is analogous. stall = stall_rs ∨ stall_rt; combinational.
- A stage X may forward when AwriteX≠0, TnewX=0, and its address matches the consumer address. The consumer address must be non-zero.
- Priority is nearest stage first. D: E > M > W. E: M > W. M: W only.
- Register $0 never matches and never stalls or forwards, even if AwriteX=0 and a source address is 0.
- Forward selects stay valid during stall. The D muxes then see the producer as it advances.

## Timing
- Reset (reset_n=0 at an edge): all shadow fields = 0. Next cycle stall=0, all Fwd*=0, stall_cnt=0.
- stall and Fwd* are combinational from the D inputs and the shadow state. They carry zero latency.
- Shadow state has 1-cycle latency per stage.
- A load followed by a dependent ALU op (Tuse=1) stalls exactly 1 cycle. The value then forwards W→E.
- A load followed by a dependent branch (Tuse=0) stalls 2 cycles. The value then forwards W→D.
- An ALU result (TnewD=2) followed by a dependent branch stalls 1 cycle, then forwards M→D.
- reset_n low during a stall clears it on that edge. The bubble and the stalled instr are both discarded.

## Configuration
- HAZARD_STAT_EN defined: a 32-bit counter increments on every edge with stall=1 and reset_n=1. It wraps 0xFFFFFFFF→0 and is driven on stall_cnt.
- HAZARD_STAT_EN undefined: the counter is not instantiated and stall_cnt is tied to 32'h0.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with arbitrary D inputs. Expect stall=0, all Fwd*=0, stall_cnt=0.
- ALU chain: addu $3 (TnewD=2), then addu reading rs=$3 (Tuse_rs=1). Expect stall=0 and FwdRsE=2 when the consumer is in E.
- Load-use: lw $5 (TnewD=3), then addu rs=$5 (Tuse_rs=1). Expect stall=1 for 1 cycle, then FwdRsE=3. With HAZARD_STAT_EN, stall_cnt=1.
- Load-branch: lw $7, then beq rs=$7, rt=$7 (Tuse=0). Expect stall=1 for 2 cycles, then FwdRsD=FwdRtD=3. With HAZARD_STAT_EN, stall_cnt=2.
- $0 writer: ori with AwriteD=0, then addu rs=$0. Expect stall=0 and FwdRsE=0.
- Priority: addu $4 in M (TnewM=0) and a lui-class $4 in W. A sw with rt=$4 entering E expects FwdRtE=2. One cycle later, in M with no newer writer, it expects FwdRtM=3.
